// File: rtl/axi_burst_pkg.sv
// Shared encodings for axi_burst_master: FSM states, AXI burst types, AXI response codes.
package axi_burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5,
    ST_DONE = 3'd6
  } state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Worst-of merge: numerically larger response code wins.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_burst_master.sv
// axi_burst_master: command-driven AXI4 master, one INCR burst per command,
// one transaction outstanding. W and R payloads pass through to valid/ready streams.
// Optional watchdog enabled by defining AXI_BURST_MASTER_TIMEOUT_EN.
module axi_burst_master
  import axi_burst_pkg::*;
#(
  parameter int                       AXI_ID_WIDTH   = 1,
  parameter int                       AXI_DATA_WIDTH = 32,
  parameter int                       AXI_ADDR_WIDTH = 32,
  parameter int                       ADDR_LSB       = $clog2(AXI_DATA_WIDTH/8),
  parameter logic [AXI_ID_WIDTH-1:0]  MASTER_ID      = '0,
  parameter int                       TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  // command
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]                  cmd_len,
  // write payload stream
  input  logic [AXI_DATA_WIDTH-1:0]   wr_data,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  // read payload stream
  output logic [AXI_DATA_WIDTH-1:0]   rd_data,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  // completion
  output logic                        done,
  output logic [1:0]                  done_resp,
  // AW
  output logic [AXI_ID_WIDTH-1:0]     awid,
  output logic [AXI_ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]                  awlen,
  output logic [2:0]                  awsize,
  output logic [1:0]                  awburst,
  output logic                        awvalid,
  input  logic                        awready,
  // W
  output logic [AXI_DATA_WIDTH-1:0]   wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] wstrb,
  output logic                        wlast,
  output logic                        wvalid,
  input  logic                        wready,
  // B
  input  logic [1:0]                  bresp,
  input  logic                        bvalid,
  output logic                        bready,
  // AR
  output logic [AXI_ID_WIDTH-1:0]     arid,
  output logic [AXI_ADDR_WIDTH-1:0]   araddr,
  output logic [7:0]                  arlen,
  output logic [2:0]                  arsize,
  output logic [1:0]                  arburst,
  output logic                        arvalid,
  input  logic                        arready,
  // R
  input  logic [AXI_DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]                  rresp,
  input  logic                        rlast,
  input  logic                        rvalid,
  output logic                        rready
);

  localparam logic [2:0] SIZE = 3'(ADDR_LSB);
  localparam logic [AXI_ADDR_WIDTH-1:0] LSB_MASK =
    AXI_ADDR_WIDTH'((64'd1 << ADDR_LSB) - 64'd1);

  state_e                      state, state_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]                  len_q;
  logic [7:0]                  cnt_q, cnt_d;
  logic [1:0]                  resp_q, resp_d;
  logic                        timeout;

  // Fixed AXI fields and state-decoded channel controls.
  assign cmd_ready = (state == ST_IDLE);

  assign awid    = MASTER_ID;
  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = SIZE;
  assign awburst = BURST_INCR;
  assign awvalid = (state == ST_AW);

  assign wdata    = wr_data;
  assign wstrb    = '1;
  assign wvalid   = (state == ST_W) & wr_valid;
  assign wr_ready = (state == ST_W) & wready;
  assign wlast    = (state == ST_W) & (cnt_q == len_q);

  assign bready = (state == ST_B);

  assign arid    = MASTER_ID;
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = SIZE;
  assign arburst = BURST_INCR;
  assign arvalid = (state == ST_AR);

  assign rd_data  = rdata;
  assign rd_valid = (state == ST_R) & rvalid;
  assign rready   = (state == ST_R) & rd_ready;

  assign done      = (state == ST_DONE);
  assign done_resp = resp_q;

`ifdef AXI_BURST_MASTER_TIMEOUT_EN
  logic [15:0] wd_q;
  logic        any_hs;
  logic        active;

  assign any_hs = (awvalid & awready) | (wvalid & wready) | (bvalid & bready) |
                  (arvalid & arready) | (rvalid & rready);
  assign active = (state == ST_AW) | (state == ST_W) | (state == ST_B) |
                  (state == ST_AR) | (state == ST_R);
  // Trip on the last cycle of the window so DONE follows exactly TIMEOUT_CYCLES stalled cycles.
  assign timeout = active & ~any_hs & (wd_q == 16'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts stalled cycles in a bus state, cleared by any handshake.
  always_ff @(posedge clk) begin
    if (rst || !active || any_hs) wd_q <= '0;
    else                          wd_q <= wd_q + 16'd1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^32'(TIMEOUT_CYCLES);
  assign timeout    = 1'b0;
`endif

  // Next-state, beat counter and response merge.
  always_comb begin
    state_d = state;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    case (state)
      ST_IDLE: if (cmd_valid) begin
        state_d = cmd_write ? ST_AW : ST_AR;
        cnt_d   = '0;
        resp_d  = RESP_OKAY;
      end
      ST_AW: if (awready) state_d = ST_W;
      ST_W: if (wr_valid && wready) begin
        if (cnt_q == len_q) state_d = ST_B;
        else                cnt_d   = cnt_q + 8'd1;
      end
      ST_B: if (bvalid) begin
        resp_d  = bresp;
        state_d = ST_DONE;
      end
      ST_AR: if (arready) state_d = ST_R;
      ST_R: if (rvalid && rd_ready) begin
        resp_d = resp_max(resp_q, rresp);
        if (rlast) begin
          state_d = ST_DONE;
        end else if (cnt_q == len_q) begin
          // slave overran the requested length without flagging rlast
          state_d = ST_DONE;
          resp_d  = RESP_SLVERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (timeout) begin
      state_d = ST_DONE;
      resp_d  = RESP_DECERR;
    end
  end

  // State and datapath registers; command latched on the accept handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt_q  <= '0;
      resp_q <= '0;
      addr_q <= '0;
      len_q  <= '0;
    end else begin
      state  <= state_d;
      cnt_q  <= cnt_d;
      resp_q <= resp_d;
      if (cmd_valid && cmd_ready) begin
        addr_q <= cmd_addr & ~LSB_MASK;
        len_q  <= cmd_len;
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Scoreboard bench for axi_burst_master with a behavioural AXI memory slave.
// Timeout scenario is built only when AXI_BURST_MASTER_TIMEOUT_EN is defined.
module tb_axi_burst_master;
  import axi_burst_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, rd_ready;
  logic        done;
  logic [1:0]  done_resp;
  logic [0:0]  awid, arid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst;
  logic        awvalid, awready, arvalid, arready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  always #5 clk = ~clk;

  axi_burst_master #(
    .AXI_ID_WIDTH(1), .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32),
    .MASTER_ID(1'b0), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .done_resp(done_resp),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  // ---------------- behavioural slave ----------------
  logic        aw_block, w_stall, no_rlast;
  logic [1:0]  r_resp_cfg;
  logic [31:0] mem [0:63];
  logic [5:0]  wptr, rptr;
  logic [7:0]  rcnt;
  logic        rbusy;

  assign awready = ~aw_block;
  assign wready  = ~w_stall;
  assign bresp   = RESP_OKAY;
  assign arready = ~rbusy;
  assign rvalid  = rbusy;
  assign rdata   = mem[rptr];
  assign rresp   = r_resp_cfg;
  assign rlast   = (rcnt == 8'd0) & ~no_rlast;

  always @(posedge clk) begin
    if (rst) begin
      bvalid <= 1'b0;
      rbusy  <= 1'b0;
      wptr   <= '0;
      rptr   <= '0;
      rcnt   <= '0;
    end else begin
      if (awvalid && awready) wptr <= awaddr[7:2];
      if (wvalid && wready) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 6'd1;
        if (wlast) bvalid <= 1'b1;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin
        rptr  <= araddr[7:2];
        rcnt  <= arlen;
        rbusy <= 1'b1;
      end
      if (rvalid && rready) begin
        rptr <= rptr + 6'd1;
        rcnt <= rcnt - 8'd1;
        if (rcnt == 8'd0) rbusy <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic [31:0] d; logic last; } wexp_t;
  wexp_t       exp_w[$];
  logic [39:0] exp_aw[$];
  logic [39:0] exp_ar[$];
  logic [31:0] exp_rd[$];
  logic [1:0]  exp_done[$];

  int checks = 0;
  int errors = 0;
  int rd_beats = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Monitor: pops expectations whenever the DUT presents a handshake or done.
  logic        done_prev = 1'b0;
  logic [39:0] m_aw, m_ar;
  wexp_t       m_w;
  logic [31:0] m_rd;
  logic [1:0]  m_dn;
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((awvalid && wvalid) || (!wr_valid && wvalid) || (!rd_ready && rready)) begin
        errors++;
        $display("FAIL invariant aw=%b w=%b wr_valid=%b rd_ready=%b rready=%b",
                 awvalid, wvalid, wr_valid, rd_ready, rready);
      end
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) fail("aw_unexpected");
        else begin
          m_aw = exp_aw.pop_front();
          chk("awaddr", awaddr, m_aw[39:8]);
          chk("awlen", awlen, m_aw[7:0]);
          chk("aw_fixed", {awid, awsize, awburst}, {1'b0, 3'd2, 2'b01});
        end
      end
      if (wvalid && wready) begin
        if (exp_w.size() == 0) fail("w_unexpected");
        else begin
          m_w = exp_w.pop_front();
          chk("wdata", wdata, m_w.d);
          chk("wlast", wlast, m_w.last);
          chk("wstrb", wstrb, 4'hF);
        end
      end
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) fail("ar_unexpected");
        else begin
          m_ar = exp_ar.pop_front();
          chk("araddr", araddr, m_ar[39:8]);
          chk("arlen", arlen, m_ar[7:0]);
          chk("ar_fixed", {arid, arsize, arburst}, {1'b0, 3'd2, 2'b01});
        end
      end
      if (rd_valid && rd_ready) begin
        rd_beats <= rd_beats + 1;
        if (exp_rd.size() == 0) fail("rd_unexpected");
        else begin
          m_rd = exp_rd.pop_front();
          chk("rd_data", rd_data, m_rd);
        end
      end
      if (done) begin
        chk("done_pulse_width", done_prev, 1'b0);
        if (exp_done.size() == 0) fail("done_unexpected");
        else begin
          m_dn = exp_done.pop_front();
          chk("done_resp", done_resp, m_dn);
        end
      end
    end
    done_prev <= done & ~rst;
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic w, input logic [31:0] a, input logic [7:0] l);
    int  n;
    logic r;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    n = 0;
    do begin
      @(negedge clk); r = cmd_ready;
      @(posedge clk); #1; n++;
    end while (!r && n < 100);
    cmd_valid = 1'b0;
    if (!r) fail("cmd_accept_timeout");
  endtask

  task automatic send_beat(input logic [31:0] d, input bit gap);
    int  n;
    logic hs;
    if (gap) begin
      wr_valid = 1'b0;
      @(posedge clk); #1;
    end
    wr_valid = 1'b1; wr_data = d;
    n = 0;
    do begin
      @(negedge clk); hs = wr_ready;
      @(posedge clk); #1; n++;
    end while (!hs && n < 200);
    wr_valid = 1'b0;
    if (!hs) fail("wr_beat_timeout");
  endtask

  task automatic wait_done();
    int  n;
    logic d;
    n = 0;
    do begin
      @(negedge clk); d = done; n++;
    end while (!d && n < 500);
    @(posedge clk); #1;
    if (!d) fail("done_timeout");
  endtask

  task automatic write_burst(input logic [31:0] a, input logic [7:0] l,
                             input logic [31:0] base, input bit gap);
    wexp_t e;
    exp_aw.push_back({a & 32'hFFFF_FFFC, l});
    for (int i = 0; i <= int'(l); i++) begin
      e.d = base + 32'(i); e.last = (i == int'(l));
      exp_w.push_back(e);
    end
    exp_done.push_back(RESP_OKAY);
    issue(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) send_beat(base + 32'(i), gap && i > 0);
    wait_done();
  endtask

  task automatic read_burst(input logic [31:0] a, input logic [7:0] l,
                            input logic [31:0] base, input logic [1:0] resp);
    exp_ar.push_back({a & 32'hFFFF_FFFC, l});
    for (int i = 0; i <= int'(l); i++) exp_rd.push_back(base + 32'(i));
    exp_done.push_back(resp);
    issue(1'b0, a, l);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    wexp_t e;
    int aw_cyc, n;
    logic d;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b1; wr_data = '0; rd_ready = 1'b1;
    aw_block = 1'b0; w_stall = 1'b0; no_rlast = 1'b0; r_resp_cfg = RESP_OKAY;
    repeat (3) @(posedge clk);
    #1;
    // reset state (wr_valid/rd_ready high to show the gating)
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, done, wlast}, 7'b0);
    chk("rst_regs", {awaddr, awlen, done_resp}, 42'b0);
    rst = 1'b0; wr_valid = 1'b0;
    @(posedge clk); #1;

    // write A0..A3 to 0x10 then read back
    write_burst(32'h10, 8'd3, 32'hA0, 1'b0);
    read_burst(32'h10, 8'd3, 32'hA0, RESP_OKAY);

    // gapped write with wready stall, then readback
    fork
      begin
        repeat (4) @(posedge clk);
        #1 w_stall = 1'b1;
        repeat (3) @(posedge clk);
        #1 w_stall = 1'b0;
      end
    join_none
    write_burst(32'h40, 8'd5, 32'hB0, 1'b1);
    chk("gap_w_all_consumed", 32'(exp_w.size()), 32'd0);
    read_burst(32'h40, 8'd5, 32'hB0, RESP_OKAY);

    // single-beat write/read
    write_burst(32'h4, 8'd0, 32'hDEADBEEF, 1'b0);
    read_burst(32'h4, 8'd0, 32'hDEADBEEF, RESP_OKAY);

    // read with rd_ready low for 5 cycles mid-burst
    fork
      begin
        int k;
        k = 0;
        while (rd_beats < 2 && k < 200) begin @(posedge clk); k++; end
        #1 rd_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 rd_ready = 1'b1;
      end
    join_none
    rd_beats = 0;
    read_burst(32'h40, 8'd5, 32'hB0, RESP_OKAY);

    // unaligned address masks down; EXOKAY beat raises done_resp
    r_resp_cfg = RESP_EXOKAY;
    read_burst(32'h13, 8'd0, 32'hA0, RESP_EXOKAY);
    r_resp_cfg = RESP_OKAY;

    // missing rlast at len: SLVERR
    no_rlast = 1'b1;
    read_burst(32'h10, 8'd1, 32'hA0, RESP_SLVERR);
    no_rlast = 1'b0;

    // reset during W beat 2 of a len=7 write
    exp_aw.push_back({32'h20, 8'd7});
    for (int i = 0; i < 8; i++) begin
      e.d = 32'hC0 + 32'(i); e.last = (i == 7);
      exp_w.push_back(e);
    end
    issue(1'b1, 32'h20, 8'd7);
    send_beat(32'hC0, 1'b0);
    send_beat(32'hC1, 1'b0);
    wr_valid = 1'b1; wr_data = 32'hC2; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_valids", {awvalid, wvalid, bready, done}, 4'b0);
    chk("midrst_state", dut.state, ST_IDLE);
    chk("midrst_cmd_ready", cmd_ready, 1'b1);
    wr_valid = 1'b0;
    exp_w.delete();
    repeat (3) @(posedge clk);
    #1;

`ifdef AXI_BURST_MASTER_TIMEOUT_EN
    // watchdog with awready held low
    aw_block = 1'b1;
    exp_done.push_back(RESP_DECERR);
    issue(1'b1, 32'h80, 8'd0);
    aw_cyc = 0; n = 0;
    do begin
      @(negedge clk);
      if (awvalid) aw_cyc++;
      d = done; n++;
    end while (!d && n < 100);
    if (!d) fail("tmo_done_timeout");
    chk("tmo_aw_cycles", 64'(aw_cyc), 64'd16);
    @(posedge clk); #1;
    chk("tmo_awvalid_after", awvalid, 1'b0);
    aw_block = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`endif

    chk("left_aw", 32'(exp_aw.size()), 32'd0);
    chk("left_ar", 32'(exp_ar.size()), 32'd0);
    chk("left_rd", 32'(exp_rd.size()), 32'd0);
    chk("left_done", 32'(exp_done.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- Command-driven AXI4 full master that issues one INCR burst per command.
- Sits directly upstream of axi_slave_mem_device and drives its AXI slave port.
- Write data enters on a valid/ready stream and becomes W beats; R beats leave on a valid/ready stream.
- One outstanding transaction at a time; a single-cycle done pulse reports completion status.

Parameters:
- AXI_ID_WIDTH, 1, width of awid/arid.
- AXI_DATA_WIDTH, 32, data bus width; must be a power of two and at least 8.
- AXI_ADDR_WIDTH, 32, address width.
- ADDR_LSB, $clog2(AXI_DATA_WIDTH/8), byte-offset bits; forced to zero on awaddr/araddr.
- MASTER_ID, 0, constant driven on awid/arid.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with AXI_BURST_MASTER_TIMEOUT_EN.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid, cmd_ready  in/out  1  command handshake.
- cmd_write  input  1  1 = write burst, 0 = read burst.
- cmd_addr  input  AXI_ADDR_WIDTH  start byte address.
- cmd_len  input  8  beats minus 1, copied to awlen/arlen.
- wr_data  input  AXI_DATA_WIDTH  write payload stream; wr_valid input, wr_ready output.
- rd_data  output  AXI_DATA_WIDTH  read payload stream; rd_valid output, rd_ready input.
- done  output  1  one-cycle completion pulse.
- done_resp  output  2  worst response of the transaction; valid while done=1.
- awid, awaddr, awlen, awsize, awburst, awvalid  output  per AXI4  write address channel.
- awready  input  1  write address ready.
- wdata, wstrb, wlast, wvalid  output  per AXI4  write data channel.
- wready  input  1  write data ready.
- bresp, bvalid  input  2/1  write response channel.
- bready  output  1  write response ready.
- arid, araddr, arlen, arsize, arburst, arvalid  output  per AXI4  read address channel.
- arready  input  1  read address ready.
- rdata, rresp, rlast, rvalid  input  per AXI4  read data channel.
- rready  output  1  read data ready.
- The AXI sideband signals (lock, cache, prot, qos, region, user) are not ports; the integrator ties them to 0 at the slave.

Behaviour:
- Reset: state IDLE. All valids, readies, done, done_resp, wlast and the beat counter are 0. Address/len registers are 0.
- Reset asserted mid-burst: every output returns to its reset value on the next edge. No completion of the open burst is attempted.
- Fixed AXI fields:
  - awsize/arsize = ADDR_LSB.
  - awburst/arburst = 2'b01 (INCR).
  - wstrb = all ones.
  - awid/arid = MASTER_ID.
  - Address = cmd_addr with the low ADDR_LSB bits cleared.
- cmd_ready = 1 only in IDLE. The command is latched on cmd_valid & cmd_ready; the FSM moves next cycle.
- FSM states: IDLE, AW, W, B, AR, R, DONE.
- IDLE -> AW if cmd_write, else -> AR.
- AW:
  - awvalid = 1 and stays stable until awready.
  - -> W on the handshake.
- W:
  - wvalid = wr_valid and wr_ready = wready (combinational pass-through); wdata = wr_data.
  - A beat completes on wvalid & wready.
  - The beat counter counts up from 0; wlast = (count == len).
  - -> B after the last beat.
- B:
  - bready = 1.
  - On bvalid, bresp is captured -> DONE.
- AR:
  - arvalid = 1 until arready, then -> R.
- R:
  - rready = rd_ready and rd_valid = rvalid (pass-through); rd_data = rdata.
  - Every beat's rresp is merged into done_resp as the numeric maximum.
  - A beat with rlast=1 -> DONE.
  - If the counter reaches len without rlast, -> DONE with done_resp = 2'b10 (SLVERR).
  - Beats that arrive after rlast belong to no transaction and must not occur; no check is made.
- DONE:
  - done = 1 for exactly one cycle -> IDLE.
  - done_resp is cleared when the next command is accepted.
- cmd_len = 0: a single beat with wlast=1 on the first W beat.
- Latency with zero-wait slave, write, len L: AW 1 cycle, W L+1 cycles, B at least 1 cycle, DONE 1 cycle.
- The counter is 8 bits and never wraps, because len is at most 255.
- awvalid and wvalid are never asserted together; W starts strictly after the AW handshake.

Optional Feature:
- Macro: AXI_BURST_MASTER_TIMEOUT_EN.
- Enabled:
  - A 16-bit watchdog clears on any handshake and counts every cycle spent in AW, W, B, AR or R.
  - When it reaches TIMEOUT_CYCLES: all valids/readies drop, -> DONE with done_resp = 2'b11.
- Disabled: no counter is built; the FSM waits indefinitely.

Decomposition:
- Package axi_burst_pkg:
  - FSM state encoding.
  - Burst-type constants: FIXED, INCR, WRAP.
  - Response constants: OKAY, EXOKAY, SLVERR, DECERR.
- Single module; a sub-module is not warranted. The counter and FSM are small, and the watchdog is a guarded always block.

Test Plan:
- Write then read, both with cmd_addr=0x10, cmd_len=3.
  - Write uses wr_data 0xA0..0xA3 against axi_slave_mem_device.
  - Required: awaddr=0x10, awlen=3, wlast only on the 4th beat, done_resp=0.
  - Readback yields 0xA0..0xA3 on rd_data, in order.
- Write with wr_valid deasserted every other cycle and slave wready stalled for 3 cycles.
  - Required: no beat lost or duplicated, wvalid never high while wr_valid is low, exactly 6 beats for len=5.
- Single beat: write cmd_len=0 of 0xDEADBEEF to 0x4, then read it back.
  - Required: wlast on the first beat, one-cycle done pulse, rd_data=0xDEADBEEF.
- Read with rd_ready held low for 5 cycles mid-burst.
  - Required: rready low in the same cycles, data order preserved, done after rlast.
- Reset asserted during W beat 2 of a len=7 write.
  - Required: next cycle awvalid=wvalid=bready=0, state IDLE, cmd_ready=1, no done pulse.
- AXI_BURST_MASTER_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, slave holding awready=0.
  - Required: done pulses after 16 cycles in AW, done_resp=2'b11, awvalid=0 afterwards.
